// File: rtl/l2_mem_pkg.sv
// Shared types and defaults for the L2 memory-port arbiter: widths, FSM states
// and the memory operation encoding.
package l2_mem_pkg;

  localparam int L2_ADDR_W = 28;   // 128-bit line granularity
  localparam int L2_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_I  = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // A requester raising read and write together is treated as a write.
  function automatic op_e decode_op(input logic rd, input logic wr);
    return (wr || !rd) ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/l2_mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant. Index 0 is the I side, index 1 the D side;
// on a tie the side that was not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_d_q;  // 1: the D side holds the most recent grant

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) gnt_o = last_d_q ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_d_q <= 1'b1;
    else if (|gnt_o)   last_d_q <= gnt_o[1];
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Shares one slow memory port between the L2 I-side and D-side memory channels:
// round-robin grant held until mem_ready, then one recovery cycle.
module l2_mem_arbiter
  import l2_mem_pkg::*;
#(
  parameter int ADDR_W = L2_ADDR_W,
  parameter int DATA_W = L2_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              pi_read,
  input  logic              pi_write,
  input  logic [ADDR_W-1:0] pi_addr,
  input  logic [DATA_W-1:0] pi_wdata,
  output logic [DATA_W-1:0] pi_rdata,
  output logic              pi_ready,
  input  logic              pd_read,
  input  logic              pd_write,
  input  logic [ADDR_W-1:0] pd_addr,
  input  logic [DATA_W-1:0] pd_wdata,
  output logic [DATA_W-1:0] pd_rdata,
  output logic              pd_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q;
  op_e               op_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] pi_rdata_q, pd_rdata_q;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (proc_reset_n),
    .req_i ({pd_read | pd_write, pi_read | pi_write}),
    .en_i  (state_q == ST_IDLE),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pi_rdata_q  <= '0;
      pd_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt[0]) begin
            op_q        <= decode_op(pi_read, pi_write);
            mem_write_q <= pi_write;
            mem_read_q  <= pi_read & ~pi_write;
            mem_addr_q  <= pi_addr;
            mem_wdata_q <= pi_wdata;
            state_q     <= ST_BUSY_I;
          end else if (gnt[1]) begin
            op_q        <= decode_op(pd_read, pd_write);
            mem_write_q <= pd_write;
            mem_read_q  <= pd_read & ~pd_write;
            mem_addr_q  <= pd_addr;
            mem_wdata_q <= pd_wdata;
            state_q     <= ST_BUSY_D;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (mem_ready) begin
            if (op_q == OP_READ) begin
              if (state_q == ST_BUSY_I) pi_rdata_q <= mem_rdata;
              else                      pd_rdata_q <= mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= ST_RECOVER;
          end
        end
        // Gives the retiring requester a cycle to drop its request before re-arbitration.
        ST_RECOVER: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign pi_ready  = mem_ready && (state_q == ST_BUSY_I);
  assign pd_ready  = mem_ready && (state_q == ST_BUSY_D);
  assign pi_rdata  = pi_rdata_q;
  assign pd_rdata  = pd_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
